// File: rtl/irq_priority_arbiter.sv
// Round-robin interrupt arbiter.
// Rising edges on the raw lines are latched into a pending register. One
// eligible (pending and enabled) source is presented to the core at a time.
// The presented source is held through ack and mret before the next
// arbitration round starts. The round-robin pointer then moves one past
// the source just served.
module irq_priority_arbiter #(
  parameter int N_SRC = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] irq_lines_i,
  input  logic [N_SRC-1:0] irq_mask_i,
  input  logic             irq_ack_i,
  input  logic             irq_ret_i,
  output logic             irq_req_o,
  output logic [3:0]       irq_id_o,
  output logic [31:0]      irq_cause_o,
  output logic [N_SRC-1:0] pending_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [N_SRC-1:0] lines_p1;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr_vec;
  logic [3:0]       id_q;
  logic [3:0]       id_d;
  logic [3:0]       rr_q;
  logic [3:0]       rr_d;
  logic [15:0]      elig16;
  logic [15:0]      mask16;
  logic [15:0]      clr16;

  // First set bit of elig at or above ptr, wrapping modulo N_SRC.
  // ptr is always below N_SRC, so one subtraction is enough to wrap.
  function automatic logic [3:0] pick_next(input logic [15:0] elig,
                                           input logic [3:0]  ptr);
    logic [4:0] idx;
    logic [3:0] sel;
    logic       found;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= 5'(N_SRC)) idx = idx - 5'(N_SRC);
      if (!found && elig[idx[3:0]]) begin
        sel   = idx[3:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // (id + 1) mod N_SRC.
  function automatic logic [3:0] wrap_inc(input logic [3:0] id);
    logic [4:0] n;
    n = {1'b0, id} + 5'd1;
    if (n >= 5'(N_SRC)) n = '0;
    return n[3:0];
  endfunction

  // Edge detect against the previous sample. The previous-line register
  // resets to zero, so a line held high through reset counts as an edge.
  assign rise     = irq_lines_i & ~lines_p1;
  assign eligible = pending_q & irq_mask_i;
  // Widen to 16 bits so a 4-bit id can index any legal N_SRC.
  assign elig16   = 16'(eligible);
  assign mask16   = 16'(irq_mask_i);

  // Next-state logic: arbitrate in IDLE, wait for ack or withdraw in REQ,
  // and wait for mret in SERVE. Ack is checked before the mask, so ack
  // wins when both happen in the same cycle.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    clr16   = '0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          id_d    = pick_next(elig16, rr_q);
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          clr16   = 16'(1) << id_q;
          state_d = SERVE;
        end else if (!mask16[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVE: begin
        if (irq_ret_i) begin
          rr_d    = wrap_inc(id_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear from ack is applied first and a new edge second.
  // A set on the same bit therefore takes priority over the clear.
  assign clr_vec   = clr16[N_SRC-1:0];
  assign pending_d = (pending_q & ~clr_vec) | rise;

  // State register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Line history, pending bits, round-robin pointer and presented id.
  // Reset clears all of them, so an in-flight transaction is abandoned.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lines_p1  <= '0;
      pending_q <= '0;
      rr_q      <= '0;
      id_q      <= '0;
    end else begin
      lines_p1  <= irq_lines_i;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
    end
  end

  // The request is decoded from the state register only.
  assign irq_req_o   = (state_q == REQ);
  assign irq_id_o    = id_q;
  assign irq_cause_o = 32'h8000_0010 + {28'd0, id_q};
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Bench for irq_priority_arbiter with N_SRC = 8.
// It applies a vector table, several hand-written corner sequences, and a
// randomized run checked against an arithmetic reference model.
module tb_irq_priority_arbiter;

  localparam int N = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  irq_lines_i;
  logic [N-1:0]  irq_mask_i;
  logic          irq_ack_i;
  logic          irq_ret_i;
  logic          irq_req_o;
  logic [3:0]    irq_id_o;
  logic [31:0]   irq_cause_o;
  logic [N-1:0]  pending_o;

  int checks = 0;
  int errors = 0;

  irq_priority_arbiter #(.N_SRC(N)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .irq_lines_i (irq_lines_i),
    .irq_mask_i  (irq_mask_i),
    .irq_ack_i   (irq_ack_i),
    .irq_ret_i   (irq_ret_i),
    .irq_req_o   (irq_req_o),
    .irq_id_o    (irq_id_o),
    .irq_cause_o (irq_cause_o),
    .pending_o   (pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] lines;
    logic       ack;
    logic       ret;
    logic       exp_req;
    logic [3:0] exp_id;
    logic [7:0] exp_pend;
  } vec_t;

  vec_t tbl [19];

  // Reference model state: phase 0 = nothing presented, 1 = presented,
  // 2 = being served.
  int       m_phase;
  int       m_rr;
  int       m_id;
  bit [7:0] m_pend;
  bit [7:0] m_prev;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Wait for the next rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    irq_lines_i = '0;
    irq_ack_i   = 1'b0;
    irq_ret_i   = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_rr    = 0;
    m_id    = 0;
    m_pend  = '0;
    m_prev  = '0;
  endtask

  // One clock of the model, computed from the old state and these inputs.
  task automatic model_step(input logic [7:0] l, input logic [7:0] m,
                            input logic a, input logic r);
    bit [7:0] rises;
    rises = l & ~m_prev;
    if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (m_phase == 0 && m_pend[j] && m[j]) begin
          m_id    = j;
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (a) begin
        m_pend[m_id] = 1'b0;
        m_phase      = 2;
      end else if (!m[m_id]) begin
        m_phase = 0;
      end
    end else if (r) begin
      m_rr    = (m_id + 1) % N;
      m_phase = 0;
    end
    m_pend = m_pend | rises;
    m_prev = l;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Two rounds of round-robin from rr=0, then a wrap from rr=6 to rr=0.
    tbl[0]  = '{8'h22, 1'b0, 1'b0, 1'b0, 4'd0, 8'h22};
    tbl[1]  = '{8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 8'h22};
    tbl[2]  = '{8'h00, 1'b1, 1'b0, 1'b0, 4'd1, 8'h20};
    tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 4'd1, 8'h20};
    tbl[4]  = '{8'h00, 1'b0, 1'b0, 1'b1, 4'd5, 8'h20};
    tbl[5]  = '{8'h00, 1'b1, 1'b0, 1'b0, 4'd5, 8'h00};
    tbl[6]  = '{8'h00, 1'b0, 1'b1, 1'b0, 4'd5, 8'h00};
    tbl[7]  = '{8'h08, 1'b0, 1'b0, 1'b0, 4'd5, 8'h08};
    tbl[8]  = '{8'h00, 1'b0, 1'b0, 1'b1, 4'd3, 8'h08};
    tbl[9]  = '{8'h00, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00};
    tbl[10] = '{8'h00, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00};
    tbl[11] = '{8'h00, 1'b0, 1'b1, 1'b0, 4'd3, 8'h00};
    tbl[12] = '{8'h82, 1'b1, 1'b0, 1'b0, 4'd3, 8'h82};
    tbl[13] = '{8'h00, 1'b0, 1'b0, 1'b1, 4'd7, 8'h82};
    tbl[14] = '{8'h00, 1'b1, 1'b0, 1'b0, 4'd7, 8'h02};
    tbl[15] = '{8'h00, 1'b0, 1'b1, 1'b0, 4'd7, 8'h02};
    tbl[16] = '{8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 8'h02};
    tbl[17] = '{8'h00, 1'b1, 1'b0, 1'b0, 4'd1, 8'h00};
    tbl[18] = '{8'h00, 1'b0, 1'b1, 1'b0, 4'd1, 8'h00};

    // Reset values are visible while reset is held; a line is held high.
    rst_i       = 1'b1;
    irq_lines_i = 8'h01;
    irq_mask_i  = 8'hFF;
    irq_ack_i   = 1'b0;
    irq_ret_i   = 1'b0;
    #1;
    check("rst_req", 32'(irq_req_o), 32'd0);
    check("rst_id", 32'(irq_id_o), 32'd0);
    check("rst_cause", irq_cause_o, 32'h8000_0010);
    check("rst_pend", 32'(pending_o), 32'd0);
    tick();
    tick();
    check("rst_hold_pend", 32'(pending_o), 32'd0);

    // A line held high through reset release counts as an edge.
    rst_i = 1'b0;
    tick();
    check("relhi_pend", 32'(pending_o), 32'h01);
    tick();
    check("relhi_req", 32'(irq_req_o), 32'd1);
    check("relhi_id", 32'(irq_id_o), 32'd0);

    // Apply the vector table, one clock per row.
    do_reset();
    irq_mask_i = 8'hFF;
    for (int i = 0; i < 19; i++) begin
      irq_lines_i = tbl[i].lines;
      irq_ack_i   = tbl[i].ack;
      irq_ret_i   = tbl[i].ret;
      tick();
      check($sformatf("tbl%0d_req", i), 32'(irq_req_o), 32'(tbl[i].exp_req));
      check($sformatf("tbl%0d_id", i), 32'(irq_id_o), 32'(tbl[i].exp_id));
      check($sformatf("tbl%0d_cause", i), irq_cause_o,
            32'h8000_0010 + 32'(tbl[i].exp_id));
      check($sformatf("tbl%0d_pend", i), 32'(pending_o), 32'(tbl[i].exp_pend));
    end
    irq_ack_i = 1'b0;
    irq_ret_i = 1'b0;

    // A masked pending bit is retained without a request.
    // The request appears once the mask is enabled.
    do_reset();
    irq_mask_i  = 8'hFB;
    irq_lines_i = 8'h04;
    tick();
    irq_lines_i = 8'h00;
    tick();
    tick();
    check("mask_req", 32'(irq_req_o), 32'd0);
    check("mask_pend", 32'(pending_o), 32'h04);
    irq_mask_i = 8'hFF;
    tick();
    tick();
    check("unmask_req", 32'(irq_req_o), 32'd1);
    check("unmask_id", 32'(irq_id_o), 32'd2);

    // Clearing the mask while in REQ withdraws the request.
    // The pending bit is kept.
    do_reset();
    irq_mask_i  = 8'hFF;
    irq_lines_i = 8'h10;
    tick();
    irq_lines_i = 8'h00;
    tick();
    check("wd_req_before", 32'(irq_req_o), 32'd1);
    check("wd_id", 32'(irq_id_o), 32'd4);
    irq_mask_i = 8'hEF;
    tick();
    check("wd_req_after", 32'(irq_req_o), 32'd0);
    check("wd_pend", 32'(pending_o), 32'h10);

    // A new edge in the same cycle as the ack keeps the bit pending.
    // The source is requested again after mret.
    do_reset();
    irq_mask_i  = 8'hFF;
    irq_lines_i = 8'h10;
    tick();
    irq_lines_i = 8'h00;
    tick();
    irq_ack_i   = 1'b1;
    irq_lines_i = 8'h10;
    tick();
    check("col_req", 32'(irq_req_o), 32'd0);
    check("col_pend", 32'(pending_o), 32'h10);
    irq_ack_i   = 1'b0;
    irq_lines_i = 8'h00;
    tick();
    check("col_serve_req", 32'(irq_req_o), 32'd0);
    check("col_serve_pend", 32'(pending_o), 32'h10);
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
    tick();
    check("col_rereq", 32'(irq_req_o), 32'd1);
    check("col_reid", 32'(irq_id_o), 32'd4);

    // Reset asserted between edges while in SERVE takes effect at once.
    // A later ack is ignored.
    do_reset();
    irq_mask_i  = 8'hFF;
    irq_lines_i = 8'h10;
    tick();
    irq_lines_i = 8'h04;
    tick();
    check("ar_pre_id", 32'(irq_id_o), 32'd4);
    irq_ack_i   = 1'b1;
    irq_lines_i = 8'h00;
    tick();
    irq_ack_i = 1'b0;
    check("ar_pre_pend", 32'(pending_o), 32'h04);
    #2;
    rst_i = 1'b1;
    #1;
    check("ar_req", 32'(irq_req_o), 32'd0);
    check("ar_id", 32'(irq_id_o), 32'd0);
    check("ar_cause", irq_cause_o, 32'h8000_0010);
    check("ar_pend", 32'(pending_o), 32'd0);
    #1;
    rst_i     = 1'b0;
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    check("ar_ack_req", 32'(irq_req_o), 32'd0);
    check("ar_ack_pend", 32'(pending_o), 32'd0);
    tick();
    check("ar_idle_req", 32'(irq_req_o), 32'd0);
    check("ar_idle_id", 32'(irq_id_o), 32'd0);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    irq_mask_i = 8'hFF;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0)
        irq_mask_i = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      irq_lines_i = 8'($urandom & $urandom & $urandom);
      irq_ack_i   = 1'($urandom_range(0, 1));
      irq_ret_i   = ($urandom_range(0, 2) == 0);
      model_step(irq_lines_i, irq_mask_i, irq_ack_i, irq_ret_i);
      tick();
      check("rnd_req", 32'(irq_req_o), 32'(m_phase == 1));
      check("rnd_id", 32'(irq_id_o), 32'(m_id));
      check("rnd_cause", irq_cause_o, 32'h8000_0010 + 32'(m_id));
      check("rnd_pend", 32'(pending_o), 32'(m_pend));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
